apu_sample_sched: RTL

Frame-rate sample scheduler that shares the audio DAC path between two sample producers: the APU mixer and a built-in test-tone source. It arbitrates producer writes into a small sample FIFO and releases exactly one 16-bit sample per 48 kHz frame to the serializer. It also flags FIFO underflow. It sits between the APU mixer / tone ROM and the I2S DAC serializer, all in the 18.432 MHz audio clock domain.

---
 rtl/apu_audio_pkg.sv | 15 +
 rtl/apu_sample_fifo.sv | 55 +++++
 rtl/apu_sample_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/apu_audio_pkg.sv
// rtl/apu_audio_pkg.sv - shared audio clocking constants, sample type and source enum
package apu_audio_pkg;

  localparam int REF_CLK     = 18432000;
  localparam int SAMPLE_RATE = 48000;
  localparam int DATA_WIDTH  = 16;

  typedef logic [DATA_WIDTH-1:0] sample_t;

  typedef enum logic {
    SRC_APU  = 1'b0,
    SRC_TONE = 1'b1
  } src_e;

endpackage

// File: rtl/apu_sample_fifo.sv
// rtl/apu_sample_fifo.sv - small synchronous sample FIFO with registered occupancy
module apu_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apu_sample_sched.sv
// rtl/apu_sample_sched.sv - frame-rate scheduler arbitrating APU/tone samples to the DAC path
module apu_sample_sched #(
  parameter int REF_CLK     = apu_audio_pkg::REF_CLK,
  parameter int SAMPLE_RATE = apu_audio_pkg::SAMPLE_RATE,
  parameter int DATA_WIDTH  = apu_audio_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          iCLK_18_4,
  input  logic                          iRST_N,
  input  logic                          iAPU_VALID,
  input  logic [DATA_WIDTH-1:0]         iAPU_DATA,
  output logic                          oAPU_READY,
  input  logic                          iTONE_VALID,
  input  logic [DATA_WIDTH-1:0]         iTONE_DATA,
  output logic                          oTONE_READY,
  input  logic                          iMUTE,
  input  logic                          iCLR_UFLOW,
  output logic [DATA_WIDTH-1:0]         oSAMPLE,
  output logic                          oSAMPLE_STB,
  output logic                          oUNDERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   oFILL
);

  import apu_audio_pkg::*;

  localparam int DIV = REF_CLK / SAMPLE_RATE;
  localparam int CW  = $clog2(DIV);

  logic [CW-1:0]         div_cnt;
  logic                  tick;
  src_e                  last;
  logic                  grant_apu;
  logic                  grant_tone;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] head;

  assign tick = (div_cnt == CW'(DIV - 1));

  // Frame divider: free-running 0..DIV-1, tick on the last count.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Round-robin grant: a lone requester wins; on a tie the source not granted last wins.
  always_comb begin
    grant_apu  = 1'b0;
    grant_tone = 1'b0;
    if (iAPU_VALID && iTONE_VALID) begin
      grant_apu  = (last == SRC_TONE);
      grant_tone = (last == SRC_APU);
    end else begin
      grant_apu  = iAPU_VALID;
      grant_tone = iTONE_VALID;
    end
  end

  // Full is registered occupancy, so a same-cycle pop never reopens ready.
  assign oAPU_READY  = grant_apu  && !full;
  assign oTONE_READY = grant_tone && !full;
  assign push        = (iAPU_VALID && oAPU_READY) || (iTONE_VALID && oTONE_READY);
  assign push_data   = oAPU_READY ? iAPU_DATA : iTONE_DATA;
  assign pop         = tick && !empty;

  // Last-grant register moves only on a completed transfer.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      last <= SRC_TONE;
    end else if (push) begin
      last <= oAPU_READY ? SRC_APU : SRC_TONE;
    end
  end

  apu_sample_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (iCLK_18_4),
    .rst_n     (iRST_N),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (oFILL),
    .full      (full),
    .empty     (empty)
  );

  // Frame output register: one strobe per tick, silence on empty or mute, sticky underflow.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      oSAMPLE     <= '0;
      oSAMPLE_STB <= 1'b0;
      oUNDERFLOW  <= 1'b0;
    end else begin
      oSAMPLE_STB <= tick;
      if (tick) begin
        oSAMPLE <= (empty || iMUTE) ? '0 : head;
      end
      if (tick && empty) begin
        oUNDERFLOW <= 1'b1;
      end else if (iCLR_UFLOW) begin
        oUNDERFLOW <= 1'b0;
      end
    end
  end

endmodule
